// File: rtl/roi_bram_capture.sv
// -----------------------------------------------------------------------------
// roi_bram_capture
//
// Captures a fixed rectangular region of interest from the demosaiced camera
// pixel stream. Each pixel is packed as RGB565 and four pixels form one
// 64-bit word. The words are written into four downstream 1024x64 BRAM banks
// that share the address and data buses. A face-filter stage later reads the
// banks as a frame snapshot.
//
// Ports:
//   iCLK          block clock (also the BRAM clock)
//   iRST_N        synchronous active-low reset
//   iSTART        one-cycle pulse that arms a capture
//   iFRAME_START  one-cycle pulse on the first cycle of each camera frame
//   iDVAL         pixel valid
//   iX_Cont       column of the current pixel
//   iY_Cont       row of the current pixel
//   iRed/iGreen/iBlue  12-bit colour components
//   oADDR         BRAM word address, shared by all banks
//   oWRDATA       BRAM write data, shared by all banks
//   oWRITE        one-hot per-bank write strobe
//   oBUSY         armed or capturing
//   oDONE         capture complete
//   oERR          sticky flag: capture was restarted by an early frame start
//   oWORD_CNT     words written in the current capture
// -----------------------------------------------------------------------------
module roi_bram_capture #(
  parameter int ROI_X0 = 256,
  parameter int ROI_Y0 = 176,
  parameter int ROI_W  = 128,
  parameter int ROI_H  = 128
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iSTART,
  input  logic        iFRAME_START,
  input  logic        iDVAL,
  input  logic [15:0] iX_Cont,
  input  logic [15:0] iY_Cont,
  input  logic [11:0] iRed,
  input  logic [11:0] iGreen,
  input  logic [11:0] iBlue,
  output logic [9:0]  oADDR,
  output logic [63:0] oWRDATA,
  output logic [3:0]  oWRITE,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oERR,
  output logic [12:0] oWORD_CNT
);

  localparam logic [15:0] X_LO   = 16'(ROI_X0);
  localparam logic [15:0] X_HI   = 16'(ROI_X0 + ROI_W - 1);
  localparam logic [15:0] Y_LO   = 16'(ROI_Y0);
  localparam logic [15:0] Y_HI   = 16'(ROI_Y0 + ROI_H - 1);
  localparam logic [13:0] LAST_K = 14'(ROI_W * ROI_H - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [13:0] k_reg, k_next;
  logic [12:0] cnt_reg, cnt_next;
  logic        err_reg, err_next;
  logic [3:0]  write_reg, write_next;
  logic [9:0]  addr_reg, addr_next;
  logic [63:0] wrdata_reg, wrdata_next;

  // Lanes 0..2 of the word being assembled; lane 3 goes straight to the
  // write data register together with the other three.
  logic [15:0] lane_reg [3];

  logic        in_roi;
  logic        accept;
  logic [1:0]  lane_sel;
  logic [15:0] pix565;

  // Low colour bits are dropped by the RGB565 pack.
  logic        unused_color_bits;
  assign unused_color_bits = ^{iRed[6:0], iGreen[5:0], iBlue[6:0]};

  assign pix565 = {iRed[11:7], iGreen[11:6], iBlue[11:7]};
  assign in_roi = (iX_Cont >= X_LO) && (iX_Cont <= X_HI) &&
                  (iY_Cont >= Y_LO) && (iY_Cont <= Y_HI);

  // State register and registered outputs.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_reg  <= S_IDLE;
      k_reg      <= '0;
      cnt_reg    <= '0;
      err_reg    <= 1'b0;
      write_reg  <= '0;
      addr_reg   <= '0;
      wrdata_reg <= '0;
    end else begin
      state_reg  <= state_next;
      k_reg      <= k_next;
      cnt_reg    <= cnt_next;
      err_reg    <= err_next;
      write_reg  <= write_next;
      addr_reg   <= addr_next;
      wrdata_reg <= wrdata_next;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_next  = state_reg;
    k_next      = k_reg;
    cnt_next    = cnt_reg;
    err_next    = err_reg;
    write_next  = '0;
    addr_next   = addr_reg;
    wrdata_next = wrdata_reg;
    accept      = 1'b0;
    lane_sel    = k_reg[1:0];

    case (state_reg)
      S_IDLE: begin
        if (iSTART) state_next = S_ARMED;
      end

      S_ARMED: begin
        if (iFRAME_START) begin
          state_next = S_CAPTURE;
          k_next     = '0;
          cnt_next   = '0;
          err_next   = 1'b0;
        end
      end

      S_CAPTURE: begin
        accept = iDVAL && in_roi;
        if (iFRAME_START) begin
          // Early frame start: drop the partial word; a coincident pixel is
          // the first pixel of the new frame and lands in lane 0.
          lane_sel = 2'd0;
          k_next   = accept ? 14'd1 : 14'd0;
          cnt_next = '0;
          err_next = 1'b1;
        end else if (accept) begin
          k_next = k_reg + 14'd1;
          if (k_reg[1:0] == 2'd3) begin
            write_next  = 4'b0001 << k_reg[13:12];
            addr_next   = k_reg[11:2];
            wrdata_next = {pix565, lane_reg[2], lane_reg[1], lane_reg[0]};
            cnt_next    = cnt_reg + 13'd1;
          end
          if (k_reg == LAST_K) state_next = S_DONE;
        end
      end

      S_DONE: begin
        if (iSTART) state_next = S_ARMED;
      end

      default: state_next = S_IDLE;
    endcase
  end

  // Lane holding registers, one per lane.
  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
        lane_reg[gi] <= '0;
      end else if (accept && (lane_sel == 2'(gi))) begin
        lane_reg[gi] <= pix565;
      end
    end
  end

  assign oADDR     = addr_reg;
  assign oWRDATA   = wrdata_reg;
  assign oWRITE    = write_reg;
  assign oBUSY     = (state_reg == S_ARMED) || (state_reg == S_CAPTURE);
  assign oDONE     = (state_reg == S_DONE);
  assign oERR      = err_reg;
  assign oWORD_CNT = cnt_reg;

endmodule

// File: doc/roi_bram_capture.md
Name: roi_bram_capture

Overview:
- Captures a fixed rectangular region of interest (ROI) from the demosaiced camera pixel stream.
- Packs pixels as RGB565, four pixels per 64-bit word, and writes the words into the four 1024x64 BRAM banks (bank 0..3) that sit directly downstream.
- Provides the frame-snapshot source for the face-filter processing that reads the banks.
- The pixel stream arrives already retimed into the iCLK domain.

Parameters:
- ROI_X0, 256, first captured column (pixel X counter value).
- ROI_Y0, 176, first captured row (pixel Y counter value).
- ROI_W, 128, ROI width in pixels. Must be a multiple of 4.
- ROI_H, 128, ROI height in rows. ROI_W*ROI_H must be at most 16384 (4 banks x 1024 words x 4 pixels).

Ports:
- iCLK  in  1  block clock; BRAM clock.
- iRST_N  in  1  synchronous active-low reset.
- iSTART  in  1  one-cycle pulse; arms a capture.
- iFRAME_START  in  1  one-cycle pulse at the first cycle of each camera frame.
- iDVAL  in  1  pixel valid.
- iX_Cont  in  16  column of the current pixel.
- iY_Cont  in  16  row of the current pixel.
- iRed  in  12  red component.
- iGreen  in  12  green component.
- iBlue  in  12  blue component.
- oADDR  out  10  BRAM word address, shared by all banks.
- oWRDATA  out  64  BRAM write data, shared by all banks.
- oWRITE  out  4  one-hot per-bank write strobe.
- oBUSY  out  1  high in ARMED or CAPTURE.
- oDONE  out  1  high in DONE.
- oERR  out  1  sticky: capture was restarted by an early frame start.
- oWORD_CNT  out  13  number of words written in the current capture.

Behaviour:
- Reset (iRST_N=0 at a rising edge): state IDLE, internal pixel index 0, and every output 0.
- Pixel pack format: {R[11:7], G[11:6], B[11:7]}.
- Word lane placement: ROI pixel k goes to bits [16*(k%4)+15 : 16*(k%4)].
- Word index w = k/4. Bank = w[11:10]. oADDR = w[9:0].
- In-ROI test: ROI_X0 <= iX_Cont <= ROI_X0+ROI_W-1 and ROI_Y0 <= iY_Cont <= ROI_Y0+ROI_H-1.
- Out-of-ROI pixels are ignored.
- The pixel index k comes from an internal counter that increments per accepted pixel. It is not computed from X/Y.
- State machine:
  - IDLE: on iSTART, go to ARMED. oERR is not cleared.
  - ARMED: on iFRAME_START, go to CAPTURE, set k=0, set oWORD_CNT=0, clear oERR. Pixels are ignored.
  - CAPTURE: each cycle with iDVAL=1 and in-ROI, latch the pixel into lane k%4 and increment k.
    - When the 4th lane is accepted (k%4==3), the next cycle asserts oWRITE[bank]=1 for exactly one cycle, with oADDR/oWRDATA valid in that cycle. Latency is 1 cycle after the 4th pixel's iDVAL cycle.
    - oWORD_CNT increments in that same cycle.
    - Back-to-back pixels every cycle are supported with no stall or drop.
  - CAPTURE completes when the last pixel (k = ROI_W*ROI_H-1) is accepted. The final write cycle also enters DONE, and oDONE rises in that cycle.
  - DONE: outputs hold. oWRITE=0. On iSTART, go to ARMED and clear oDONE. oWORD_CNT holds until the next frame start in ARMED.
- iFRAME_START during CAPTURE (before completion): restart at k=0 and oWORD_CNT=0, set oERR=1, stay in CAPTURE.
  - The partially filled word is discarded.
  - If this pulse coincides with an accepted pixel, the pixel belongs to the new frame and is placed in lane 0 of word 0.
- iSTART in ARMED or CAPTURE is ignored.
- iFRAME_START in IDLE or DONE is ignored.
- oWRITE is only ever one-hot or zero.
- When oWRITE=0, oADDR and oWRDATA hold their last values.
- oBUSY = (ARMED or CAPTURE). oDONE = DONE.

Test Plan:
- Reset, then idle: all outputs 0. iFRAME_START and pixels without iSTART -> no oWRITE, state stays IDLE.
- Full capture with the default ROI:
  - Stimulus: iSTART, iFRAME_START, then a 640x480 raster at 1 pixel/cycle with pixel value = ROI index k.
  - Required: 4096 writes. Word 0 goes to bank 0, addr 0. Word 1023 goes to bank 0, addr 1023. Word 1024 goes to bank 1, addr 0. Word 4095 goes to bank 3, addr 1023.
  - Required: each oWRDATA lane equals the RGB565 pack of the expected k.
  - Required: oDONE=1 and oWORD_CNT=4096 in the final write cycle.
- Packing and latency:
  - Stimulus: ROI pixels R=12'hFFF,G=0,B=0, then G=12'hFFF, then B=12'hFFF, then 12'h000, on consecutive cycles.
  - Required: one cycle after the 4th pixel, oWRDATA=64'h0000_001F_07E0_F800 and oWRITE=4'b0001.
- Edge filtering: pixels at X=255, X=384, Y=175 and Y=304 are never written. Pixels at X=256 and X=383 on row 176 are written.
- Early frame start:
  - Stimulus: a second iFRAME_START after 6 ROI pixels (1 word written).
  - Required: oERR=1, oWORD_CNT=0, and the next write is bank 0, addr 0 containing the new frame's pixels 0-3.
- Re-arm behaviour:
  - Stimulus: iSTART in DONE.
  - Required: oDONE=0, oBUSY=1, and no writes until the next iFRAME_START.
  - Stimulus: iSTART mid-CAPTURE. Required: no effect.
  - Stimulus: iRST_N=0 mid-CAPTURE. Required: IDLE, all outputs 0 next cycle.
